l1_arbiter: RTL and testbench

- Shares the single L2 cache port between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between the two L1 caches and the L2 cache.
- Serves one outstanding transaction at a time and alternates round-robin when both caches request together.
- Latches address and write data at grant time, so the L2 side sees stable values for the whole transaction.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/l1_arb_pick.sv | 20 ++
 rtl/register.sv | 17 +
 rtl/l1_arbiter.sv | 116 +++++++++++
 tb/tb_l1_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word plus the L1/L2 arbiter state and operation encodings.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    I_READ,
    D_READ,
    D_WRITE
  } arb_op_t;

  // SRC_D encodes as 0 so a cleared last_grant lets the I-cache win the first tie.
  typedef enum logic {
    SRC_D = 1'b0,
    SRC_I = 1'b1
  } arb_src_t;

endpackage

// File: rtl/l1_arb_pick.sv
// Combinational round-robin pick between the I-cache and D-cache requests.
module l1_arb_pick
  import rv32i_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output logic     valid,
  output arb_src_t winner
);

  always_comb begin
    valid  = i_req | d_req;
    winner = SRC_I;
    // On a tie the side that did not win last time goes next.
    if (i_req && d_req) winner = (last_grant == SRC_I) ? SRC_D : SRC_I;
    else if (d_req)     winner = SRC_D;
  end

endmodule

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-low clear.
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/l1_arbiter.sv
// Shares the single L2 port between the I-cache and D-cache, one transaction at a time,
// with address and write data latched at grant so L2 sees stable values.
module l1_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = $bits(rv32i_word)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t        state, next_state;
  arb_src_t          winner_q, last_grant, pick_winner;
  arb_op_t           op_q, grant_op;
  logic              pick_valid;
  logic              load_addr, load_wdata, load_rdata;
  logic [ADDR_W-1:0] grant_addr;
  logic [LINE_W-1:0] rdata_reg;

  l1_arb_pick u_pick (
    .i_req     (icache_read),
    .d_req     (dcache_read | dcache_write),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  // Every L2/L1 strobe decodes from state and op_q only, never from request inputs.
  always_comb begin : state_actions
    load_addr    = 1'b0;
    load_wdata   = 1'b0;
    load_rdata   = 1'b0;
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    grant_addr   = (winner_q == SRC_I) ? icache_addr : dcache_addr;
    grant_op     = (winner_q == SRC_I) ? I_READ : (dcache_write ? D_WRITE : D_READ);
    unique case (state)
      GRANT: begin
        load_addr  = 1'b1;
        load_wdata = (grant_op == D_WRITE);
      end
      BUSY: begin
        l2_read    = (op_q != D_WRITE);
        l2_write   = (op_q == D_WRITE);
        load_rdata = l2_resp && (op_q != D_WRITE);
      end
      DONE: begin
        icache_resp = (op_q == I_READ);
        dcache_resp = (op_q != I_READ);
      end
      default: ;
    endcase
  end

  always_comb begin : next_state_logic
    next_state = state;
    unique case (state)
      IDLE:    if (pick_valid) next_state = GRANT;
      GRANT:   next_state = BUSY;
      BUSY:    if (l2_resp) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_register
    if (!reset_n) begin
      state      <= IDLE;
      winner_q   <= SRC_D;
      op_q       <= I_READ;
      last_grant <= SRC_D;
    end else begin
      state <= next_state;
      if (state == IDLE && pick_valid) winner_q <= pick_winner;
      if (state == GRANT) begin
        op_q       <= grant_op;
        last_grant <= winner_q;
      end
    end
  end

  register #(.WIDTH(ADDR_W)) u_addr_reg (
    .clk(clk), .reset_n(reset_n), .load(load_addr), .d(grant_addr), .q(l2_addr)
  );

  register #(.WIDTH(LINE_W)) u_wdata_reg (
    .clk(clk), .reset_n(reset_n), .load(load_wdata), .d(dcache_wdata), .q(l2_wdata)
  );

  register #(.WIDTH(LINE_W)) u_rdata_reg (
    .clk(clk), .reset_n(reset_n), .load(load_rdata), .d(l2_rdata), .q(rdata_reg)
  );

  assign icache_rdata = rdata_reg;
  assign dcache_rdata = rdata_reg;

endmodule

// File: tb/tb_l1_arbiter.sv
// Directed self-checking bench for l1_arbiter: single requesters, ties, stalls, and reset abort.
module tb_l1_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              icache_read, dcache_read, dcache_write, l2_resp;
  logic [ADDR_W-1:0] icache_addr, dcache_addr, l2_addr;
  logic [LINE_W-1:0] icache_rdata, dcache_rdata, dcache_wdata, l2_wdata, l2_rdata;
  logic              icache_resp, dcache_resp, l2_read, l2_write;

  int checks = 0;
  int errors = 0;

  l1_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one transaction from IDLE (request already driven) back to IDLE.
  task automatic applyStimulus(input string tag, input bit exp_i, input bit exp_write,
                               input logic [ADDR_W-1:0] exp_addr,
                               input logic [LINE_W-1:0] exp_wdata, input int stall,
                               input logic [LINE_W-1:0] rdata, input bit perturb);
    tick();
    checkOutput($sformatf("%s grant rd", tag), l2_read, 0);
    checkOutput($sformatf("%s grant wr", tag), l2_write, 0);
    tick();
    for (int k = 0; k <= stall; k++) begin
      checkOutput($sformatf("%s busy%0d rd", tag, k), l2_read, !exp_write);
      checkOutput($sformatf("%s busy%0d wr", tag, k), l2_write, exp_write);
      checkOutput($sformatf("%s busy%0d addr", tag, k), l2_addr, exp_addr);
      if (exp_write)
        checkOutput($sformatf("%s busy%0d wdata", tag, k), l2_wdata, exp_wdata);
      checkOutput($sformatf("%s busy%0d resp", tag, k), {icache_resp, dcache_resp}, 0);
      if (perturb) begin
        dcache_addr  = ~exp_addr;
        dcache_wdata = ~exp_wdata;
      end
      if (k == stall) begin
        l2_resp  = 1'b1;
        l2_rdata = rdata;
      end
      tick();
    end
    l2_resp  = 1'b0;
    l2_rdata = '0;
    checkOutput($sformatf("%s done iresp", tag), icache_resp, exp_i);
    checkOutput($sformatf("%s done dresp", tag), dcache_resp, !exp_i);
    checkOutput($sformatf("%s done strobes", tag), {l2_read, l2_write}, 0);
    if (!exp_write) begin
      if (exp_i) checkOutput($sformatf("%s irdata", tag), icache_rdata, rdata);
      else       checkOutput($sformatf("%s drdata", tag), dcache_rdata, rdata);
    end
    if (exp_i) icache_read = 1'b0;
    else begin
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
    end
    tick();
    checkOutput($sformatf("%s idle resp", tag), {icache_resp, dcache_resp}, 0);
  endtask

  localparam logic [LINE_W-1:0] RD_A = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] RD_B = {8{32'h0BADF00D}};
  localparam logic [LINE_W-1:0] RD_C = {8{32'hCAFE1234}};
  localparam logic [LINE_W-1:0] WD_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] WD_12 = {8{32'h12345678}};

  initial begin
    reset_n = 1'b0;
    icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0; l2_resp = 1'b0;
    icache_addr = '0; dcache_addr = '0; dcache_wdata = '0; l2_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst strobes", {l2_read, l2_write}, 0);
    checkOutput("rst resp", {icache_resp, dcache_resp}, 0);
    checkOutput("rst addr", l2_addr, 0);
    checkOutput("rst wdata", l2_wdata, 0);
    checkOutput("rst irdata", icache_rdata, 0);
    checkOutput("rst drdata", dcache_rdata, 0);
    reset_n = 1'b1;
    tick();

    // Ties after reset alternate I, D, I, D.
    icache_read = 1'b1; icache_addr = 32'h0000_0100;
    dcache_read = 1'b1; dcache_addr = 32'h0000_0200;
    applyStimulus("tie1", 1, 0, 32'h0000_0100, '0, 0, RD_A, 0);
    icache_read = 1'b1; icache_addr = 32'h0000_0140;
    applyStimulus("tie2", 0, 0, 32'h0000_0200, '0, 0, RD_B, 0);
    dcache_read = 1'b1; dcache_addr = 32'h0000_0240;
    applyStimulus("tie3", 1, 0, 32'h0000_0140, '0, 0, RD_C, 0);
    applyStimulus("tie4", 0, 0, 32'h0000_0240, '0, 0, RD_A, 0);

    icache_read = 1'b1; icache_addr = 32'h0000_1000;
    applyStimulus("ionly", 1, 0, 32'h0000_1000, '0, 1, RD_B, 0);

    dcache_write = 1'b1; dcache_addr = 32'h0000_2040; dcache_wdata = WD_A5;
    applyStimulus("dwr", 0, 1, 32'h0000_2040, WD_A5, 0, RD_C, 0);

    dcache_write = 1'b1; dcache_addr = 32'h0000_3080; dcache_wdata = WD_12;
    applyStimulus("dwr_hold", 0, 1, 32'h0000_3080, WD_12, 2, RD_C, 1);

    dcache_read = 1'b1; dcache_addr = 32'h0000_40C0;
    applyStimulus("stall", 0, 0, 32'h0000_40C0, '0, 20, RD_A, 0);
    tick();
    checkOutput("stall single resp", {icache_resp, dcache_resp}, 0);

    // Reset while BUSY abandons the transaction.
    icache_read = 1'b1; icache_addr = 32'h0000_5000;
    tick();
    tick();
    checkOutput("abort busy rd", l2_read, 1);
    reset_n = 1'b0;
    icache_read = 1'b0;
    #1;
    checkOutput("abort rd async", l2_read, 0);
    checkOutput("abort addr clr", l2_addr, 0);
    @(posedge clk);
    #1;
    checkOutput("abort resp", {icache_resp, dcache_resp}, 0);
    reset_n = 1'b1;
    tick();
    checkOutput("post rst resp", {icache_resp, dcache_resp}, 0);
    checkOutput("post rst strobes", {l2_read, l2_write}, 0);

    icache_read = 1'b1; icache_addr = 32'h0000_6000;
    dcache_read = 1'b1; dcache_addr = 32'h0000_7000;
    applyStimulus("post rst i", 1, 0, 32'h0000_6000, '0, 0, RD_B, 0);
    applyStimulus("post rst d", 0, 0, 32'h0000_7000, '0, 0, RD_C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
